// File: rtl/conv_maxpool_writer_pkg.sv
// Shared constants and row-state encoding for the 2x2/stride-2 max-pool writer
// that sits behind the convolution engine.
package conv_maxpool_writer_pkg;

  localparam int LEN_OF_OUTPUT      = 25;
  localparam int NUM_OF_PER_OUT_ROW = 61;
  localparam int NUM_OF_POOL_ROW    = 30;
  localparam int POOL_PLANE         = 900;
  localparam int LEN_OF_ADDR        = 15;
  localparam int KERNEL_W           = 5;

  // data1 on beat 0 carries no column; the engine fills it with all ones (-1)
  localparam logic signed [LEN_OF_OUTPUT-1:0] BEAT0_MARKER = '1;

  typedef enum logic [1:0] {
    ROW_EVEN = 2'd0,
    ROW_ODD  = 2'd1,
    ROW_DROP = 2'd2,
    ST_DONE  = 2'd3
  } row_state_t;

endpackage

// File: rtl/conv_maxpool_writer_pool_line_buffer.sv
// Holds the horizontal maxima of the current even conv row until the odd row
// below it arrives; synchronous write, combinational indexed read.
module pool_line_buffer #(
  parameter int W     = 25,
  parameter int DEPTH = 30,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic signed [W-1:0] i_wdata,
  input  logic [AW-1:0]       i_raddr,
  output logic signed [W-1:0] o_rdata
);

  logic signed [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/conv_maxpool_writer.sv
// Max-pools the 61x61 ReLU'd conv planes down to 30x30 and emits one pooled
// value per cycle with its flat result-memory address.
module conv_maxpool_writer
  import conv_maxpool_writer_pkg::*;
#(
  parameter int lenOfOutput    = LEN_OF_OUTPUT,
  parameter int numOfPerOutRow = NUM_OF_PER_OUT_ROW,
  parameter int numOfPoolRow   = NUM_OF_POOL_ROW,
  parameter int lenOfAddr      = LEN_OF_ADDR
) (
  input  logic                          clk,
  input  logic                          in_rst,
  input  logic                          in_write_ctl,
  input  logic signed [lenOfOutput-1:0] in_data0,
  input  logic signed [lenOfOutput-1:0] in_data1,
  input  logic                          in_end_conv,
  output logic                          out_pool_valid,
  output logic signed [lenOfOutput-1:0] out_pool_data,
  output logic [lenOfAddr-1:0]          out_pool_addr,
  output logic                          out_done,
  output logic                          out_err
);

  localparam int BEAT_W = $clog2(numOfPoolRow + 1);
  localparam int ROW_W  = $clog2(numOfPerOutRow);
  localparam int IDX_W  = $clog2(numOfPoolRow);

  localparam logic [BEAT_W-1:0]   LAST_BEAT   = BEAT_W'(numOfPoolRow);
  localparam logic [ROW_W-1:0]    LAST_POOLED = ROW_W'(numOfPerOutRow - 2);
  localparam logic [KERNEL_W-1:0] LAST_KERNEL = '1;
  localparam logic [lenOfAddr-1:0] ROW_STEP   = lenOfAddr'(numOfPoolRow);
  localparam logic [lenOfAddr-1:0] PLANE_STEP = lenOfAddr'(POOL_PLANE);

  row_state_t                   r_state;
  logic [BEAT_W-1:0]            r_beat_cnt;
  logic [ROW_W-1:0]             r_row_cnt;
  logic [KERNEL_W-1:0]          r_kernel_cnt;
  logic signed [lenOfOutput-1:0] r_even_hold;
  logic [lenOfAddr-1:0]         r_row_base;
  logic [lenOfAddr-1:0]         r_kernel_base;

  logic                          w_beat;
  logic                          w_last_beat;
  logic [BEAT_W-1:0]             w_j_full;
  logic [IDX_W-1:0]              w_j;
  logic signed [lenOfOutput-1:0] w_hmax;
  logic signed [lenOfOutput-1:0] w_lb_rdata;
  logic signed [lenOfOutput-1:0] w_vmax;
  logic                          w_lb_we;

  assign w_beat      = in_write_ctl && (r_state != ST_DONE);
  assign w_last_beat = (r_beat_cnt == LAST_BEAT);
  assign w_j_full    = r_beat_cnt - BEAT_W'(1);
  assign w_j         = w_j_full[IDX_W-1:0];
  assign w_hmax      = (r_even_hold > in_data0) ? r_even_hold : in_data0;
  assign w_vmax      = (w_lb_rdata > w_hmax) ? w_lb_rdata : w_hmax;
  assign w_lb_we     = w_beat && (r_state == ROW_EVEN) && (r_beat_cnt != '0);

  pool_line_buffer #(
    .W     (lenOfOutput),
    .DEPTH (numOfPoolRow),
    .AW    (IDX_W)
  ) u_line_buf (
    .clk     (clk),
    .i_we    (w_lb_we),
    .i_waddr (w_j),
    .i_wdata (w_hmax),
    .i_raddr (w_j),
    .o_rdata (w_lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (in_rst) begin
      r_state        <= ROW_EVEN;
      r_beat_cnt     <= '0;
      r_row_cnt      <= '0;
      r_kernel_cnt   <= '0;
      r_even_hold    <= '0;
      r_row_base     <= '0;
      r_kernel_base  <= '0;
      out_pool_valid <= 1'b0;
      out_pool_data  <= '0;
      out_pool_addr  <= '0;
      out_done       <= 1'b0;
      out_err        <= 1'b0;
    end else begin
      out_pool_valid <= 1'b0;

      if (w_beat) begin
        if (r_beat_cnt == '0) begin
          r_even_hold <= in_data0;
          if (in_data1 != BEAT0_MARKER) begin
            out_err <= 1'b1;
          end
        end else begin
          // data1 of the last beat is the dropped column; holding it is harmless
          r_even_hold <= in_data1;
          if (r_state == ROW_ODD) begin
            out_pool_valid <= 1'b1;
            out_pool_data  <= w_vmax;
            out_pool_addr  <= r_row_base + lenOfAddr'(w_j);
          end
        end

        if (w_last_beat) begin
          r_beat_cnt <= '0;
          case (r_state)
            ROW_EVEN: begin
              r_row_cnt <= r_row_cnt + ROW_W'(1);
              r_state   <= ROW_ODD;
            end
            ROW_ODD: begin
              r_row_cnt  <= r_row_cnt + ROW_W'(1);
              r_row_base <= r_row_base + ROW_STEP;
              r_state    <= (r_row_cnt == LAST_POOLED) ? ROW_DROP : ROW_EVEN;
            end
            ROW_DROP: begin
              r_row_cnt    <= '0;
              r_kernel_cnt <= r_kernel_cnt + KERNEL_W'(1);
              r_state      <= ROW_EVEN;
              if (r_kernel_cnt == LAST_KERNEL) begin
                r_kernel_base <= '0;
                r_row_base    <= '0;
              end else begin
                r_kernel_base <= r_kernel_base + PLANE_STEP;
                r_row_base    <= r_kernel_base + PLANE_STEP;
              end
            end
            default: r_state <= ST_DONE;
          endcase
        end else begin
          r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
        end
      end

      if (in_write_ctl && (r_state == ST_DONE)) begin
        out_err <= 1'b1;
      end

      if (in_end_conv) begin
        r_state  <= ST_DONE;
        out_done <= 1'b1;
        if (r_beat_cnt != '0) begin
          out_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_maxpool_writer.sv
// Scoreboard bench: expected pooled values are computed from the generated
// conv rows as beats are driven and matched against each output pulse.
module tb_conv_maxpool_writer;

  logic               clk;
  logic               in_rst;
  logic               in_write_ctl;
  logic signed [24:0] in_data0;
  logic signed [24:0] in_data1;
  logic               in_end_conv;
  logic               out_pool_valid;
  logic signed [24:0] out_pool_data;
  logic [14:0]        out_pool_addr;
  logic               out_done;
  logic               out_err;

  typedef struct {
    int data;
    int addr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;

  conv_maxpool_writer dut (
    .clk            (clk),
    .in_rst         (in_rst),
    .in_write_ctl   (in_write_ctl),
    .in_data0       (in_data0),
    .in_data1       (in_data1),
    .in_end_conv    (in_end_conv),
    .out_pool_valid (out_pool_valid),
    .out_pool_data  (out_pool_data),
    .out_pool_addr  (out_pool_addr),
    .out_done       (out_done),
    .out_err        (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int val(input int mode, input int k, input int r, input int c);
    if (mode == 0) return k * 10000 + r * 100 + c;
    if (r == 0 && c == 0) return -5;
    if (r == 0 && c == 1) return -3;
    if (r == 1 && c == 0) return -7;
    if (r == 1 && c == 1) return -9;
    return (((r * 37 + c * 53 + k * 11) % 201) - 100) * 1000;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  always @(negedge clk) begin
    if (out_pool_valid) begin
      exp_t e;
      n_out++;
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("pool_addr", int'(out_pool_addr), e.addr);
        check("pool_data", int'(out_pool_data), e.data);
        $display("pool addr=%0d data=%0d", out_pool_addr, out_pool_data);
      end
    end
  end

  task automatic beat(input int d0, input int d1, input bit exp_valid, input int gap);
    in_write_ctl = 1'b1;
    in_data0     = 25'(d0);
    in_data1     = 25'(d1);
    @(posedge clk); #1;
    in_write_ctl = 1'b0;
    check("valid_latency", int'(out_pool_valid), int'(exp_valid));
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_row(input int mode, input int k, input int r, input int gap, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      int  d0, d1, j;
      bit  ev;
      exp_t e;
      d0 = val(mode, k, r, (b == 0) ? 0 : 2 * b - 1);
      d1 = (b == 0) ? -1 : val(mode, k, r, 2 * b);
      ev = (r % 2 == 1) && (r < 60) && (b > 0);
      if (ev) begin
        j = b - 1;
        e.data = max2(max2(val(mode, k, r - 1, 2 * j), val(mode, k, r - 1, 2 * j + 1)),
                      max2(val(mode, k, r, 2 * j), val(mode, k, r, 2 * j + 1)));
        e.addr = k * 900 + (r / 2) * 30 + j;
        sb.push_back(e);
      end
      beat(d0, d1, ev, gap);
    end
  endtask

  task automatic drive_kernel(input int mode, input int k, input int gap);
    for (int r = 0; r < 61; r++) drive_row(mode, k, r, gap, 31);
  endtask

  task automatic do_reset();
    in_rst = 1'b1;
    @(posedge clk); #1;
    in_rst = 1'b0;
  endtask

  task automatic end_conv();
    in_end_conv = 1'b1;
    @(posedge clk); #1;
    in_end_conv = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    in_rst       = 1'b1;
    in_write_ctl = 1'b0;
    in_data0     = '0;
    in_data1     = '0;
    in_end_conv  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_rst = 1'b0;

    check("rst_valid", int'(out_pool_valid), 0);
    check("rst_data", int'(out_pool_data), 0);
    check("rst_addr", int'(out_pool_addr), 0);
    check("rst_done", int'(out_done), 0);
    check("rst_err", int'(out_err), 0);

    // two kernels back to back, ramp values
    drive_kernel(0, 0, 0);
    @(negedge clk); #1;
    check("k0_outputs", n_out, 900);
    check("k0_done", int'(out_done), 0);
    drive_kernel(0, 1, 0);
    end_conv();
    check("k1_outputs", n_out, 1800);
    check("k1_done", int'(out_done), 1);
    check("k1_err", int'(out_err), 0);

    // gapped beats
    do_reset();
    check("gap_done_cleared", int'(out_done), 0);
    n_out = 0;
    drive_kernel(0, 0, 5);
    check("gap_outputs", n_out, 900);

    // negative / mixed values
    do_reset();
    drive_kernel(1, 0, 0);
    end_conv();
    check("neg_err", int'(out_err), 0);
    check("neg_done", int'(out_done), 1);

    // reset in the middle of row 1, coinciding with beat 14
    do_reset();
    drive_row(0, 0, 0, 0, 31);
    drive_row(0, 0, 1, 0, 14);
    in_rst       = 1'b1;
    in_write_ctl = 1'b1;
    in_data0     = 25'(127);
    in_data1     = 25'(128);
    @(posedge clk); #1;
    in_rst       = 1'b0;
    in_write_ctl = 1'b0;
    check("midrst_valid", int'(out_pool_valid), 0);
    check("midrst_addr", int'(out_pool_addr), 0);
    check("midrst_queue", sb.size(), 0);
    drive_kernel(0, 0, 0);
    end_conv();
    check("restart_err", int'(out_err), 0);

    // beat while done
    beat(1, -1, 1'b0, 0);
    check("done_beat_err", int'(out_err), 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_err_sticky", int'(out_err), 1);
    do_reset();
    check("err_cleared", int'(out_err), 0);

    // beat 0 with bad marker
    beat(4, 0, 1'b0, 0);
    check("marker_err", int'(out_err), 1);
    beat(1, 2, 1'b0, 2);
    check("marker_err_sticky", int'(out_err), 1);

    // end of conv in the middle of a row
    do_reset();
    beat(4, -1, 1'b0, 0);
    check("pre_endmid_err", int'(out_err), 0);
    end_conv();
    check("endmid_err", int'(out_err), 1);
    check("endmid_done", int'(out_done), 1);

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_maxpool_writer.md
# conv_maxpool_writer

Downstream stage of the convolution top module. Consumes the ReLU'd 61-wide output rows it streams (two values per beat, gated by its write-control strobe), applies 2×2 stride-2 max pooling per kernel plane (61×61 → 30×30, row 60 and column 60 dropped), and emits one pooled value per cycle with a flat output-memory address. Sits between the conv engine and the result SRAM/testbench sink.

## Interface
Parameters:
- lenOfOutput, 25, width of conv results and pooled values
- numOfPerOutRow, 61, conv output row/column count
- numOfPoolRow, 30, pooled row/column count (numOfPerOutRow/2, floor)
- lenOfAddr, 15, pooled address width (32 kernels × 900)

Ports:
- clk  input  1  clock
- in_rst  input  1  reset; one clock, synchronous, active-high
- in_write_ctl  input  1  beat strobe from conv engine
- in_data0  input  25 signed  first value of beat
- in_data1  input  25 signed  second value of beat (−1 on beat 0, ignored)
- in_end_conv  input  1  conv engine finished all kernels
- out_pool_valid  output  1  pooled value valid this cycle
- out_pool_data  output  25 signed  pooled value
- out_pool_addr  output  15  kernel×900 + prow×30 + pcol
- out_done  output  1  sticky: all pooled data emitted
- out_err  output  1  sticky protocol error

## Operation
- Beat format per conv row (31 beats): beat 0 = {col0, −1}; beat k (1..30) = {col 2k−1, col 2k}. Beats need not be consecutive; only cycles with in_write_ctl=1 count.
- Counters: beatCnt 0..30, rowCnt 0..60, kernelCnt 0..31. After beat 30: beatCnt←0, rowCnt++; rowCnt 60→0 with kernelCnt++.
- Row states (derived from rowCnt): ROW_EVEN (rowCnt even, <60), ROW_ODD, ROW_DROP (rowCnt=60); plus DONE.
- Horizontal pairing: evenHold register captures col 2j (data0 on beat 0, data1 on beats 1..29); on beat j+1 (j=0..29) hmax = max(evenHold, data0). data1 of beat 30 (col 60) discarded.
- ROW_EVEN: lineBuf[j] ← hmax (30×25-bit buffer).
- ROW_ODD: out_pool_data ← max(lineBuf[j], hmax), out_pool_addr ← kernelCnt×900 + (rowCnt>>1)×30 + j, out_pool_valid ← 1.
- ROW_DROP: beats consumed, nothing written or emitted.
- All compares signed; no saturation (width unchanged).
- out_err set (sticky) if in_write_ctl=1 while in DONE, or if in_data1 ≠ −1 on beat 0. Erroneous beats still update counters (except in DONE).
- in_end_conv=1 → next cycle enter DONE, out_done←1; sticky until in_rst. in_end_conv while beatCnt≠0 also sets out_err.

## Timing
- Reset values: out_pool_valid=0, out_pool_data=0, out_pool_addr=0, out_done=0, out_err=0; all counters, evenHold, state cleared; lineBuf contents don't-care (always written before read).
- Latency: pooled value j registered one cycle after the odd-row beat j+1 is sampled; valid is a one-cycle pulse per value; max throughput 1 value/cycle.
- Last pooled value (kernel k, prow 29, pcol 29) appears the cycle after beat 30 of row 59; out_done asserts no earlier than one cycle after in_end_conv is sampled.
- in_rst mid-row: everything returns to reset values next cycle; partial row discarded; next beat treated as beat 0 row 0 kernel 0.
- in_rst and in_write_ctl same cycle: reset wins, beat dropped.

## Structure
- Shared package: lenOfOutput, numOfPerOutRow, numOfPoolRow, pooled plane size 900, beat-0 marker (−1), row-state encoding.
- One sub-module: pool_line_buffer (30×25-bit, one write port and one read port, synchronous write, combinational read by index).
- Address computed incrementally (base += 30 per odd row, += 900 per kernel), no multipliers.

## Test plan
- One kernel, value(r,c)=r×100+c, back-to-back beats → 900 pulses; (prow 2, pcol 3) data 507, addr 63; final addr 899 data 5959.
- Two kernels (kernel 1 values +10000) → kernel 1 first output addr 900 data 10101; row 60 and col 60 never appear.
- Beats with 5-cycle gaps between each → identical data/addr sequence, each valid one cycle after its odd-row beat.
- Negative and mixed values, e.g. row0 col0=−5, col1=−3, row1 col0=−7, col1=−9 → output −3 at addr 0.
- in_rst asserted at beat 14 of row 1 → no further valid; restart stream → first output addr 0 with correct data.
- Beat after out_done, and beat 0 with data1=0 → out_err=1 and stays 1 until in_rst; no extra valid pulses.
